// File: rtl/control_unit_gen2_if.sv
// Control-unit bus bundle: instruction fetch, datapath control and FSM
// observation signals shared between the control unit and its environment.
interface control_unit_gen2_if #(
   parameter int RF_ADDR_W = 4,
   parameter int PC_W      = 7
);
   localparam int D_ADDR_W = 2 * RF_ADDR_W;
   localparam int INST_W   = 4 + 3 * RF_ADDR_W;

   logic [INST_W-1:0]    I_Data;
   logic                 Alu_Z;
   logic [PC_W-1:0]      I_Addr;
   logic [PC_W-1:0]      PC_Out;
   logic [INST_W-1:0]    IR_Out;
   logic [3:0]           OutState;
   logic [3:0]           NextState;
   logic [D_ADDR_W-1:0]  D_Addr;
   logic                 D_Wr;
   logic                 RF_s;
   logic                 RF_W_en;
   logic [RF_ADDR_W-1:0] RF_W_Addr;
   logic [RF_ADDR_W-1:0] RF_Ra_Addr;
   logic [RF_ADDR_W-1:0] RF_Rb_Addr;
   logic [2:0]           Alu_s0;

   modport master (
      input  I_Data, Alu_Z,
      output I_Addr, PC_Out, IR_Out, OutState, NextState,
      output D_Addr, D_Wr, RF_s, RF_W_en,
      output RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, Alu_s0
   );

   modport slave (
      output I_Data, Alu_Z,
      input  I_Addr, PC_Out, IR_Out, OutState, NextState,
      input  D_Addr, D_Wr, RF_s, RF_W_en,
      input  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, Alu_s0
   );
endinterface

// File: rtl/control_unit_gen2.sv
// Multi-cycle Moore control unit: fetch/decode/execute sequencer driving
// instruction memory, data memory, register file and ALU controls.
module control_unit_gen2 #(
   parameter int RF_ADDR_W = 4,
   parameter int PC_W      = 7
) (
   input  logic               Clk,
   input  logic               ResetN,
   control_unit_gen2_if.master bus
);
   localparam int R  = RF_ADDR_W;
   localparam int DW = 2 * R;
   localparam int IW = 4 + 3 * R;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9,
      S_JUMP   = 4'd10
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0]   ir_q, ir_d;

   logic [3:0]      op;
   logic [R-1:0]    f2, f1, f0;
   logic [DW-1:0]   daddr_hi, daddr_lo;
   logic [PC_W-1:0] target;

   logic [DW-1:0]   d_addr;
   logic            d_wr, rf_s, rf_w_en;
   logic [R-1:0]    rf_w, rf_ra, rf_rb;
   logic [2:0]      alu_s0;

   assign op       = ir_q[IW-1 -: 4];
   assign f2       = ir_q[3*R-1 -: R];
   assign f1       = ir_q[2*R-1 -: R];
   assign f0       = ir_q[R-1:0];
   assign daddr_hi = {f2, f1};
   assign daddr_lo = {f1, f0};
   assign target   = daddr_lo[PC_W-1:0];

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= S_INIT;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = S_INIT;
      pc_d    = pc_q;
      ir_d    = ir_q;
      d_addr  = '0;
      d_wr    = 1'b0;
      rf_s    = 1'b0;
      rf_w_en = 1'b0;
      rf_w    = '0;
      rf_ra   = '0;
      rf_rb   = '0;
      alu_s0  = 3'b000;
      case (state_q)
         S_INIT: state_d = S_FETCH;
         S_FETCH: begin
            state_d = S_DECODE;
            ir_d    = bus.I_Data;
            pc_d    = pc_q + PC_W'(1);
         end
         S_DECODE: begin
            rf_ra = f2;
            rf_rb = f1;
            unique case (op)
               4'b0001: state_d = S_STORE;
               4'b0010: state_d = S_LOAD_A;
               4'b0011: state_d = S_ADD;
               4'b0100: state_d = S_SUB;
               4'b0101: state_d = S_HALT;
               4'b0110: state_d = S_JUMP;
               4'b0111: state_d = bus.Alu_Z ? S_JUMP : S_NOOP;
               default: state_d = S_NOOP;
            endcase
            // Target lands in PC here so Jump can present it to memory
            if (state_d == S_JUMP) pc_d = target;
         end
         S_LOAD_A, S_LOAD_B: begin
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_FETCH;
            d_addr  = daddr_hi;
            rf_s    = 1'b1;
            rf_w    = f0;
            rf_w_en = (state_q == S_LOAD_B);
         end
         S_STORE: begin
            state_d = S_FETCH;
            d_addr  = daddr_lo;
            rf_ra   = f2;
            d_wr    = 1'b1;
         end
         S_ADD, S_SUB: begin
            state_d = S_FETCH;
            rf_ra   = f2;
            rf_rb   = f1;
            rf_w    = f0;
            rf_w_en = 1'b1;
            alu_s0  = (state_q == S_ADD) ? 3'b001 : 3'b010;
         end
         S_NOOP, S_JUMP: state_d = S_FETCH;
         S_HALT: state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

   assign bus.I_Addr     = pc_q;
   assign bus.PC_Out     = pc_q;
   assign bus.IR_Out     = ir_q;
   assign bus.OutState   = state_q;
   assign bus.NextState  = state_d;
   assign bus.D_Addr     = d_addr;
   assign bus.D_Wr       = d_wr;
   assign bus.RF_s       = rf_s;
   assign bus.RF_W_en    = rf_w_en;
   assign bus.RF_W_Addr  = rf_w;
   assign bus.RF_Ra_Addr = rf_ra;
   assign bus.RF_Rb_Addr = rf_rb;
   assign bus.Alu_s0     = alu_s0;
endmodule

// File: tb/tb_control_unit_gen2.sv
// Bench for control_unit_gen2: directed program, halt, abort-on-reset and
// random programs checked against an instruction-level reference model.
module tb_control_unit_gen2;
   localparam int R  = 4;
   localparam int PW = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   control_unit_gen2_if #(.RF_ADDR_W(R), .PC_W(PW)) bus();

   control_unit_gen2 #(.RF_ADDR_W(R), .PC_W(PW)) dut (
      .Clk(clk),
      .ResetN(rst_n),
      .bus(bus)
   );

   logic [15:0] rom [128];
   always @(posedge clk) bus.I_Data <= rom[bus.I_Addr];

   int n_chk = 0;
   int n_pass = 0;
   int pc_m;
   logic [15:0] ir_m;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [25:0] ov(int da, int dwr, int rfs, int wen,
                                      int w, int ra, int rb, int alu);
      return {da[7:0], dwr[0], rfs[0], wen[0], w[3:0], ra[3:0], rb[3:0], alu[2:0]};
   endfunction

   function automatic logic [25:0] dut_o();
      return {bus.D_Addr, bus.D_Wr, bus.RF_s, bus.RF_W_en,
              bus.RF_W_Addr, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.Alu_s0};
   endfunction

   function automatic logic [37:0] dut_c();
      return {bus.OutState, bus.NextState, bus.PC_Out, bus.I_Addr, bus.IR_Out};
   endfunction

   task automatic cyc(string tag, int st, int ns, int pc, logic [15:0] ir,
                      logic [25:0] o);
      check({tag, "/ctl"}, 64'(dut_c()), 64'({st[3:0], ns[3:0], pc[6:0], pc[6:0], ir}));
      check({tag, "/out"}, 64'(dut_o()), 64'(o));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 cyc("reset", 0, 1, 0, 16'h0000, 26'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 cyc("init", 0, 1, 0, 16'h0000, 26'd0);
      pc_m = 0;
      ir_m = 16'h0000;
   endtask

   // One instruction, Fetch through its last execute cycle.
   task automatic run_instr(int zf);
      logic [15:0] in;
      int op, f2, f1, f0, hi, lo, pc1, epc, n, z;
      int est [2];
      logic [25:0] eo [2];
      string t;
      in  = rom[pc_m];
      op  = int'(in[15:12]);
      f2  = int'(in[11:8]);
      f1  = int'(in[7:4]);
      f0  = int'(in[3:0]);
      hi  = f2 * 16 + f1;
      lo  = f1 * 16 + f0;
      pc1 = (pc_m + 1) % 128;
      t   = $sformatf("pc%0h_op%0d", pc_m, op);
      @(negedge clk);
      bus.Alu_Z = 1'($urandom);
      #1 cyc({t, "/fetch"}, 1, 2, pc_m, ir_m, 26'd0);
      @(negedge clk);
      z = (zf < 0) ? int'($urandom % 2) : zf;
      bus.Alu_Z = z[0];
      epc = pc1;
      n = 1;
      est[0] = 3;
      eo[0] = 26'd0;
      case (op)
         1: begin est[0] = 6; eo[0] = ov(lo, 1, 0, 0, 0, f2, 0, 0); end
         2: begin
            n = 2;
            est[0] = 4; eo[0] = ov(hi, 0, 1, 0, f0, 0, 0, 0);
            est[1] = 5; eo[1] = ov(hi, 0, 1, 1, f0, 0, 0, 0);
         end
         3: begin est[0] = 7; eo[0] = ov(0, 0, 0, 1, f0, f2, f1, 1); end
         4: begin est[0] = 8; eo[0] = ov(0, 0, 0, 1, f0, f2, f1, 2); end
         5: est[0] = 9;
         6: begin est[0] = 10; epc = lo % 128; end
         7: if (z == 1) begin est[0] = 10; epc = lo % 128; end
         default: ;
      endcase
      #1 cyc({t, "/decode"}, 2, est[0], pc1, in, ov(0, 0, 0, 0, 0, f2, f1, 0));
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.Alu_Z = 1'($urandom);
         #1 cyc({t, "/exec"}, est[i],
                (i + 1 < n) ? est[i+1] : ((op == 5) ? 9 : 1),
                epc, in, eo[i]);
      end
      pc_m = epc;
      ir_m = in;
   endtask

   initial begin
      bus.Alu_Z = 1'b0;
      foreach (rom[i]) rom[i] = 16'h0000;

      // Directed program, including NOOP, LOAD, ADD, SUB, JMP, STORE, JZ, wrap
      rom[8'h00] = 16'h0000;
      rom[8'h01] = 16'h2A53;
      rom[8'h02] = 16'h3123;
      rom[8'h03] = 16'h4123;
      rom[8'h04] = 16'h6006;
      rom[8'h06] = 16'h1312;
      rom[8'h07] = 16'h7040;
      rom[8'h08] = 16'h7040;
      rom[8'h40] = 16'h607F;
      rom[8'h7F] = 16'h0000;
      rom[8'h05] = 16'h9ABC;
      do_reset();
      for (int i = 0; i < 6; i++) run_instr(-1);
      run_instr(0);
      run_instr(1);
      run_instr(-1);
      run_instr(-1);
      check("wrap_pc", 64'(bus.PC_Out), 64'd0);

      // Halt holds for 20 cycles with PC frozen
      rom[0] = 16'h5000;
      do_reset();
      run_instr(-1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1 cyc("halt", 9, 9, 1, 16'h5000, 26'd0);
      end

      // Reset pulse in Load_A aborts before Load_B
      rom[0] = 16'h2A53;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1 cyc("loada", 4, 5, 1, 16'h2A53, ov(8'hA5, 0, 1, 0, 3, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1 cyc("abort", 0, 1, 0, 16'h0000, 26'd0);
      @(negedge clk);
      #1 cyc("abort_hold", 0, 1, 0, 16'h0000, 26'd0);
      rst_n = 1'b1;
      pc_m = 0;
      ir_m = 16'h0000;
      run_instr(-1);
      run_instr(-1);

      // Random programs, HALT excluded so the run keeps going
      foreach (rom[i]) begin
         rom[i] = 16'($urandom);
         if (rom[i][15:12] == 4'h5) rom[i][15:12] = 4'h3;
      end
      do_reset();
      for (int i = 0; i < 250; i++) run_instr(-1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
